// File: rtl/name_hash_pkg.sv
// Shared constants, H3 hash matrix rows and FSM state encoding for the name-hash scheduler.
package name_hash_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned HASH_W = 10;

  // Row i is XORed into the word hash when bit i of the word is set
  localparam logic [HASH_W-1:0] H3_ROW [0:DATA_W-1] = '{
    10'h3B5, 10'h020, 10'h1C3, 10'h2A7, 10'h0F1, 10'h36C, 10'h159, 10'h28E,
    10'h0B4, 10'h3D2, 10'h147, 10'h06A, 10'h2F9, 10'h113, 10'h38D, 10'h0C6,
    10'h25B, 10'h17E, 10'h3A1, 10'h049, 10'h1D8, 10'h2C3, 10'h096, 10'h33F,
    10'h16D, 10'h0E2, 10'h2B5, 10'h3C8, 10'h051, 10'h19A, 10'h27C, 10'h0A3,
    10'h31E, 10'h1B7, 10'h04D, 10'h2E0, 10'h12C, 10'h3F6, 10'h089, 10'h265,
    10'h1F3, 10'h0D9, 10'h34A, 10'h21F, 10'h07B, 10'h1A4, 10'h39C, 10'h0E8,
    10'h2D1, 10'h15F, 10'h03E, 10'h3B2, 10'h166, 10'h29D, 10'h0C1, 10'h378,
    10'h1E5, 10'h24A, 10'h09F, 10'h31C, 10'h183, 10'h2FE, 10'h05C, 10'h2C7
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/name_hash_core.sv
// Combinational H3 word hash: XOR of the matrix rows selected by the set bits of the word.
module name_hash_core
  import name_hash_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  output logic [HASH_W-1:0] hash_c
);

  always_comb begin
    hash_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (word_i[i]) hash_c = hash_c ^ H3_ROW[i];
    end
  end

endmodule

// File: rtl/name_hash_sched.sv
// Round-robin scheduler sharing one H3 name-hash engine among NUM_REQ word-streaming requesters.
module name_hash_sched
  import name_hash_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [HASH_W-1:0]         res_hash,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_trunc,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      g_q, g_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [HASH_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic                 trunc_q, trunc_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [HASH_W-1:0]    res_hash_q, res_hash_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic                 res_trunc_q, res_trunc_d;
  logic                 busy_q, busy_d;

  logic [DATA_W-1:0]    word_c;
  logic [HASH_W-1:0]    word_hash_c;
  logic [HASH_W-1:0]    acc_fold_c;
  logic                 beat_c;
  logic                 found_c;
  logic [ID_W-1:0]      grant_c;
  int unsigned          idx;

  // Search starts just after the last served requester
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!found_c && req_valid[ID_W'(idx)]) begin
        found_c = 1'b1;
        grant_c = ID_W'(idx);
      end
    end
  end

  always_comb begin
    word_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g_q == ID_W'(i)) word_c = req_data[i*DATA_W +: DATA_W];
    end
  end

  name_hash_core u_core (
    .word_i (word_c),
    .hash_c (word_hash_c)
  );

  assign acc_fold_c = {acc_q[HASH_W-2:0], acc_q[HASH_W-1]} ^ word_hash_c;
  assign beat_c     = req_valid[g_q] & req_ready_q[g_q];

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    wcnt_d       = wcnt_q;
    trunc_d      = trunc_q;
    req_ready_d  = req_ready_q;
    res_valid_d  = res_valid_q;
    res_hash_d   = res_hash_q;
    res_id_d     = res_id_q;
    res_trunc_d  = res_trunc_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          g_d         = grant_c;
          acc_d       = '0;
          wcnt_d      = '0;
          trunc_d     = 1'b0;
          req_ready_d = NUM_REQ'(1) << grant_c;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (beat_c) begin
          // Words beyond MAX_WORDS are drained but leave the hash untouched
          if (wcnt_q < CNT_W'(MAX_WORDS)) begin
            acc_d  = acc_fold_c;
            wcnt_d = wcnt_q + CNT_W'(1);
          end else begin
            trunc_d = 1'b1;
          end
          if (req_last[g_q]) begin
            req_ready_d = '0;
            res_valid_d = 1'b1;
            res_hash_d  = acc_d;
            res_id_d    = g_q;
            res_trunc_d = trunc_d;
            state_d     = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          last_grant_d = g_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      g_q          <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      acc_q        <= '0;
      wcnt_q       <= '0;
      trunc_q      <= 1'b0;
      req_ready_q  <= '0;
      res_valid_q  <= 1'b0;
      res_hash_q   <= '0;
      res_id_q     <= '0;
      res_trunc_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      wcnt_q       <= wcnt_d;
      trunc_q      <= trunc_d;
      req_ready_q  <= req_ready_d;
      res_valid_q  <= res_valid_d;
      res_hash_q   <= res_hash_d;
      res_id_q     <= res_id_d;
      res_trunc_q  <= res_trunc_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_hash  = res_hash_q;
  assign res_id    = res_id_q;
  assign res_trunc = res_trunc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_name_hash_sched.sv
// Scoreboard bench for name_hash_sched: directed names, round-robin, truncation, backpressure, reset abort.
module tb_name_hash_sched;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic [9:0]   res_hash;
  logic [1:0]   res_id;
  logic         res_trunc;
  logic         busy;

  typedef struct packed {
    logic [9:0] hash;
    logic [1:0] id;
    logic       trunc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   beats    = 0;

  name_hash_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hash  (res_hash),
    .res_id    (res_id),
    .res_trunc (res_trunc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  // Monitor: one-hot ready, accepted-beat count, result scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL ready_onehot got=%b want at most one bit", req_ready);
      end
      beats += $countones(req_valid & req_ready);
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got hash=%h id=%0d trunc=%0b want none", res_hash, res_id, res_trunc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({res_hash, res_id, res_trunc} !== e) begin
            failures++;
            $display("FAIL result got hash=%h id=%0d trunc=%0b want hash=%h id=%0d trunc=%0b",
                     res_hash, res_id, res_trunc, e.hash, e.id, e.trunc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input logic [9:0] h, input logic [1:0] id, input logic tr);
    exp_t e;
    e.hash = h; e.id = id; e.trunc = tr;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted
  task automatic send_beat(input int id, input logic [63:0] w, input logic l);
    int n;
    n = 0;
    req_valid[id] = 1'b1;
    req_data[id*64 +: 64] = w;
    req_last[id] = l;
    while (!req_ready[id]) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout req=%0d got no ready want ready", id);
        break;
      end
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy || exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout got busy=%0b pending=%0d want idle", busy, exp_q.size());
        break;
      end
    end
  endtask

  initial begin
    int c0;
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({req_ready, res_valid, res_hash, res_id, res_trunc, busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat, requester 0, plus latency
    push(10'h3B5, 2'd0, 1'b0);
    c0 = cyc;
    send_beat(0, 64'h1, 1'b1);
    check("single_latency", 64'({res_valid, 8'(cyc - c0)}), 64'({1'b1, 8'd2}));

    // Two beats, requester 1
    push(10'h0DE, 2'd1, 1'b0);
    send_beat(1, 64'h1, 1'b0);
    send_beat(1, 64'h1, 1'b1);

    // Multi-bit word, requester 2; zero word, requester 3
    push(10'h395, 2'd2, 1'b0);
    send_beat(2, 64'h3, 1'b1);
    push(10'h000, 2'd3, 1'b0);
    send_beat(3, 64'h0, 1'b1);
    wait_idle();

    // All four requesting at once: order 0,1,2,3,0
    push(10'h3B5, 2'd0, 1'b0);
    push(10'h020, 2'd1, 1'b0);
    push(10'h395, 2'd2, 1'b0);
    push(10'h2C7, 2'd3, 1'b0);
    push(10'h3B5, 2'd0, 1'b0);
    fork
      begin send_beat(0, 64'h1, 1'b1); send_beat(0, 64'h1, 1'b1); end
      send_beat(1, 64'h2, 1'b1);
      send_beat(2, 64'h3, 1'b1);
      send_beat(3, 64'h8000_0000_0000_0000, 1'b1);
    join
    wait_idle();

    // Ten beats with result backpressure: truncated, hash of first eight
    beats     = 0;
    res_ready = 1'b0;
    push(10'h1C8, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) send_beat(0, 64'h1, (i == 9));
    check("trunc_res_valid", 64'(res_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_result", 64'({res_valid, res_hash, res_id, res_trunc}), 64'({1'b1, 10'h1C8, 2'd0, 1'b1}));
    end
    check("trunc_beats", 64'(beats), 64'd10);
    res_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a four-beat name
    send_beat(0, 64'h1, 1'b0);
    send_beat(0, 64'h1, 1'b0);
    check("mid_name_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", 64'({req_ready, res_valid, res_hash, res_id, res_trunc, busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset requester 0 wins over requester 1
    push(10'h020, 2'd0, 1'b0);
    push(10'h395, 2'd1, 1'b0);
    fork
      send_beat(0, 64'h2, 1'b1);
      send_beat(1, 64'h3, 1'b1);
    join
    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
